// File: rtl/keypad_scan_ctrl.sv
// 4x4 matrix keypad scanner: drives one row at a time, debounces whole-frame
// results and queues accepted key presses in a small event FIFO.
module keypad_scan_ctrl #(
    parameter int SETTLE_CYC   = 4,
    parameter int DEBOUNCE_CNT = 3,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk_div,
    input  logic       rst,
    input  logic       scan_en,
    input  logic [3:0] keyCol,
    output logic [3:0] keyRow,
    output logic       key_valid,
    output logic [3:0] key_value,
    input  logic       key_ready,
    output logic       overflow
);

    localparam int            AW          = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   DEPTH_L     = (AW+1)'(FIFO_DEPTH);
    localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [3:0]    DEB         = 4'(DEBOUNCE_CNT);

    typedef enum logic       {ST_DISABLED, ST_SCAN}         state_t;
    typedef enum logic [1:0] {RES_NONE, RES_KEY, RES_MULTI} res_t;
    typedef enum logic       {DB_RELEASED, DB_PRESSED}      db_t;

    state_t      state, state_nx;
    logic [1:0]  row;
    logic [7:0]  settle;
    logic [1:0]  acc_cnt;
    logic [3:0]  acc_code;
    res_t        prev_res;
    logic [3:0]  prev_code;
    logic [3:0]  deb_cnt;
    db_t         db_state;

    logic [3:0]  pressed;
    logic [2:0]  hits;
    logic [3:0]  row_code;
    logic        sample;
    logic        frame_end;
    logic [1:0]  comb_cnt;
    logic [3:0]  comb_code;
    res_t        res;
    logic        same;
    logic [3:0]  deb_cnt_nx;
    logic        push;
    logic        release_ev;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop;
    logic          accept;

    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [3:0] p);
        logic [1:0] c;
        logic [3:0] code;
        c = p[0] ? 2'd0 : p[1] ? 2'd1 : p[2] ? 2'd2 : 2'd3;
        case ({r, c})
            4'h0: code = 4'h7;
            4'h1: code = 4'h4;
            4'h2: code = 4'h1;
            4'h3: code = 4'h0;
            4'h4: code = 4'h8;
            4'h5: code = 4'h5;
            4'h6: code = 4'h2;
            4'h7: code = 4'hA;
            4'h8: code = 4'h9;
            4'h9: code = 4'h6;
            4'hA: code = 4'h3;
            4'hB: code = 4'hB;
            4'hC: code = 4'hC;
            4'hD: code = 4'hD;
            4'hE: code = 4'hE;
            default: code = 4'hF;
        endcase
        return code;
    endfunction

    always_ff @(posedge clk_div) begin
        if (rst) state <= ST_DISABLED;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        keyRow   = 4'b1111;
        case (state)
            ST_DISABLED: if (scan_en)  state_nx = ST_SCAN;
            ST_SCAN: begin
                keyRow = ~(4'b0001 << row);
                if (!scan_en) state_nx = ST_DISABLED;
            end
            default: state_nx = ST_DISABLED;
        endcase
    end

    // Frame result accumulates a saturating hit count (0, 1, 2+) across rows.
    always_comb begin
        pressed    = ~keyCol;
        hits       = {2'b00, pressed[0]} + {2'b00, pressed[1]}
                   + {2'b00, pressed[2]} + {2'b00, pressed[3]};
        row_code   = key_code(row, pressed);
        sample     = (state == ST_SCAN) && scan_en && (settle == SETTLE_LAST);
        frame_end  = sample && (row == 2'd3);
        comb_cnt   = acc_cnt;
        comb_code  = acc_code;
        if (hits == 3'd1 && acc_cnt == 2'd0) begin
            comb_cnt  = 2'd1;
            comb_code = row_code;
        end else if (hits != 3'd0) begin
            comb_cnt  = 2'd2;
        end
        case (comb_cnt)
            2'd0:    res = RES_NONE;
            2'd1:    res = RES_KEY;
            default: res = RES_MULTI;
        endcase
        same       = (deb_cnt != 4'd0) && (res == prev_res)
                   && ((res != RES_KEY) || (comb_code == prev_code));
        deb_cnt_nx = !same ? 4'd1 : (deb_cnt == DEB) ? DEB : deb_cnt + 4'd1;
        push       = frame_end && (db_state == DB_RELEASED) && (res == RES_KEY)
                   && (deb_cnt_nx == DEB);
        release_ev = frame_end && (db_state == DB_PRESSED) && (res == RES_NONE)
                   && (deb_cnt_nx == DEB);
    end

    // Leaving SCAN (or sitting in DISABLED) keeps all scan/debounce state cleared.
    always_ff @(posedge clk_div) begin
        if (rst || state != ST_SCAN || state_nx != ST_SCAN) begin
            row       <= '0;
            settle    <= '0;
            acc_cnt   <= '0;
            acc_code  <= '0;
            prev_res  <= RES_NONE;
            prev_code <= '0;
            deb_cnt   <= '0;
            db_state  <= DB_RELEASED;
        end else if (sample) begin
            settle <= '0;
            row    <= row + 2'd1;
            if (row == 2'd3) begin
                acc_cnt   <= '0;
                acc_code  <= '0;
                prev_res  <= res;
                prev_code <= comb_code;
                deb_cnt   <= deb_cnt_nx;
                if (push)            db_state <= DB_PRESSED;
                else if (release_ev) db_state <= DB_RELEASED;
            end else begin
                acc_cnt  <= comb_cnt;
                acc_code <= comb_code;
            end
        end else begin
            settle <= settle + 8'd1;
        end
    end

    assign key_valid = (count != '0);
    assign key_value = key_valid ? mem[rd_ptr] : '0;
    assign pop       = key_valid && key_ready;
    assign accept    = push && ((count != DEPTH_L) || pop);

    always_ff @(posedge clk_div) begin
        if (accept) mem[wr_ptr] <= comb_code;
    end

    always_ff @(posedge clk_div) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            else if (push) overflow <= 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Self-checking bench for keypad_scan_ctrl: keypad matrix model, directed
// frame-level sequences, a vector table and a randomized reference-model run.
module tb_keypad_scan_ctrl;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;
    localparam int DEPTH  = 4;
    localparam int FRAME  = 4 * SETTLE;

    logic       clk_div = 1'b0;
    logic       rst, scan_en, key_ready;
    logic [3:0] keyCol, keyRow, key_value;
    logic       key_valid, overflow;
    logic [15:0] press;

    int n_pass  = 0;
    int n_total = 0;
    logic [3:0] popped[$];
    bit  watch_stable = 1'b0;
    int  stable_bad   = 0;

    // Spec key map, index = row*4 + col
    int code_tbl [16] = '{7, 4, 1, 0, 8, 5, 2, 10, 9, 6, 3, 11, 12, 13, 14, 15};

    typedef struct {
        logic [15:0] keys;
        int          nfr;
        int          exp_events;
        int          exp_code;
    } vec_t;
    vec_t vecs [19];

    always #5 clk_div = ~clk_div;

    // Passive keypad: a pressed switch pulls its column low while its row is driven.
    always_comb begin
        keyCol = 4'b1111;
        for (int r = 0; r < 4; r++)
            if (!keyRow[r])
                for (int c = 0; c < 4; c++)
                    if (press[r*4 + c]) keyCol[c] = 1'b0;
    end

    keypad_scan_ctrl #(
        .SETTLE_CYC  (SETTLE),
        .DEBOUNCE_CNT(DEB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk_div  (clk_div),
        .rst      (rst),
        .scan_en  (scan_en),
        .keyCol   (keyCol),
        .keyRow   (keyRow),
        .key_valid(key_valid),
        .key_value(key_value),
        .key_ready(key_ready),
        .overflow (overflow)
    );

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step();
        if (key_valid === 1'b1 && key_ready) popped.push_back(key_value);
        if (watch_stable && key_valid === 1'b1 && key_value != 4'h1) stable_bad++;
        @(posedge clk_div);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n * FRAME) step();
    endtask

    task automatic start_scan();
        rst = 1'b1; scan_en = 1'b0;
        step(); step();
        rst = 1'b0; scan_en = 1'b1;
        step();
    endtask

    task automatic press_key(input int idx, input int n);
        press = 16'h0001 << idx;
        frames(n);
        press = '0;
    endtask

    task automatic pulse_event(input int idx);
        press_key(idx, 3);
        frames(3);
    endtask

    function automatic int head(input int i);
        return (popped.size() > i) ? int'(popped[i]) : -1;
    endfunction

    function automatic int frame_result(input logic [15:0] k);
        int n, code;
        n = 0; code = -1;
        for (int i = 0; i < 16; i++)
            if (k[i]) begin n++; code = code_tbl[i]; end
        if (n == 0) return -1;
        if (n == 1) return code;
        return -2;
    endfunction

    initial begin
        vecs[0]  = '{16'h0001, 3, 1, 7};
        vecs[1]  = '{16'h0002, 3, 1, 4};
        vecs[2]  = '{16'h0004, 3, 1, 1};
        vecs[3]  = '{16'h0008, 3, 1, 0};
        vecs[4]  = '{16'h0010, 3, 1, 8};
        vecs[5]  = '{16'h0020, 3, 1, 5};
        vecs[6]  = '{16'h0040, 3, 1, 2};
        vecs[7]  = '{16'h0080, 3, 1, 10};
        vecs[8]  = '{16'h0100, 3, 1, 9};
        vecs[9]  = '{16'h0200, 3, 1, 6};
        vecs[10] = '{16'h0400, 3, 1, 3};
        vecs[11] = '{16'h0800, 3, 1, 11};
        vecs[12] = '{16'h1000, 3, 1, 12};
        vecs[13] = '{16'h2000, 3, 1, 13};
        vecs[14] = '{16'h4000, 3, 1, 14};
        vecs[15] = '{16'h8000, 3, 1, 15};
        vecs[16] = '{16'h0020, 2, 0, 0};
        vecs[17] = '{16'h0041, 4, 0, 0};
        vecs[18] = '{16'h8000, 6, 1, 15};

        // Reset dominates scan_en, key_ready and a pressed key
        rst = 1'b1; scan_en = 1'b1; key_ready = 1'b1; press = 16'h0040;
        step(); step();
        check("rst_keyRow", keyRow, 4'hF);
        check("rst_valid", key_valid, 0);
        check("rst_value", key_value, 0);
        check("rst_ovf", overflow, 0);

        // r1/c2 held 10 frames: one event of 2 visible after edge 48
        popped.delete();
        rst = 1'b0;
        step();
        check("start_row", keyRow, 4'hE);
        repeat (47) step();
        check("valid_before_48", key_valid, 0);
        step();
        check("valid_at_48", key_valid, 1);
        check("value_at_48", key_value, 2);
        repeat (10 * FRAME - 48) step();
        check("hold_events", popped.size(), 1);
        check("hold_code", head(0), 2);
        press = '0;
        frames(4);

        // Bounce on r0/c0
        popped.delete();
        press_key(0, 2); frames(1); press_key(0, 2); frames(4);
        check("bounce_none", popped.size(), 0);
        press_key(0, 3); frames(1);
        check("bounce_events", popped.size(), 1);
        check("bounce_code", head(0), 7);
        frames(3);

        // Two keys together
        popped.delete();
        press = (16'h0001 << 11) | (16'h0001 << 12);
        frames(5);
        press = '0;
        frames(4);
        check("multi_events", popped.size(), 0);
        check("multi_ovf", overflow, 0);

        for (int i = 0; i < 19; i++) begin
            popped.delete();
            press = vecs[i].keys;
            frames(vecs[i].nfr);
            press = '0;
            frames(4);
            check($sformatf("tbl%0d_events", i), popped.size(), vecs[i].exp_events);
            if (vecs[i].exp_events > 0)
                check($sformatf("tbl%0d_code", i), head(0), vecs[i].exp_code);
        end

        // Five presses into a 4-deep FIFO with no consumer
        key_ready = 1'b0;
        watch_stable = 1'b1;
        pulse_event(2); pulse_event(6); pulse_event(10); pulse_event(1); pulse_event(5);
        watch_stable = 1'b0;
        check("full_head_stable", stable_bad, 0);
        check("full_valid", key_valid, 1);
        check("full_value", key_value, 1);
        check("full_ovf", overflow, 1);
        key_ready = 1'b1;
        popped.delete();
        repeat (6) step();
        check("drain_cnt", popped.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("drain%0d", i), head(i), i + 1);
        check("drain_valid", key_valid, 0);

        // Push into a full FIFO in the same cycle as a pop
        start_scan();
        check("ovf_after_rst", overflow, 0);
        check("valid_after_rst", key_valid, 0);
        key_ready = 1'b0;
        pulse_event(2); pulse_event(6); pulse_event(10); pulse_event(1);
        press = 16'h8000;
        repeat (47) step();
        key_ready = 1'b1;
        step();
        key_ready = 1'b0;
        press = '0;
        check("simul_ovf", overflow, 0);
        check("simul_head", key_value, 2);
        key_ready = 1'b1;
        popped.delete();
        repeat (5) step();
        check("simul_cnt", popped.size(), 4);
        check("simul_first", head(0), 2);
        check("simul_last", head(3), 15);
        check("simul_empty", key_valid, 0);

        // Reset mid-frame with two entries queued
        start_scan();
        key_ready = 1'b0;
        pulse_event(2); pulse_event(6);
        repeat (5) step();
        check("q2_valid", key_valid, 1);
        rst = 1'b1;
        step();
        check("midrst_keyRow", keyRow, 4'hF);
        check("midrst_valid", key_valid, 0);
        check("midrst_value", key_value, 0);
        check("midrst_ovf", overflow, 0);

        // Disable mid-frame aborts debounce progress
        start_scan();
        key_ready = 1'b1;
        popped.delete();
        press = 16'h8000;
        frames(2);
        repeat (8) step();
        scan_en = 1'b0;
        step();
        check("dis_keyRow", keyRow, 4'hF);
        scan_en = 1'b1;
        step();
        check("reen_keyRow", keyRow, 4'hE);
        frames(2);
        check("reen_no_early", popped.size(), 0);
        frames(1);
        press = '0;
        frames(4);
        check("reen_events", popped.size(), 1);
        check("reen_code", head(0), 15);

        // Randomized run against a frame-level reference model
        begin
            int q_m[$];
            int last_res, run, held, cyc, ready_pct, res, r, a, b;
            bit ovf_m, pop_m, push_m;
            start_scan();
            q_m.delete();
            last_res = -99; run = 0; held = -1; cyc = 0; ovf_m = 1'b0; ready_pct = 50;
            press = '0;
            for (int f = 0; f < 80; f++) begin
                if (f % 10 == 0) ready_pct = int'($urandom_range(0, 3)) * 30;
                r = int'($urandom_range(0, 99));
                if (r < 55) press = press;
                else if (r < 75) press = '0;
                else if (r < 93) press = 16'h0001 << $urandom_range(0, 15);
                else begin
                    a = int'($urandom_range(0, 15));
                    b = (a + 1 + int'($urandom_range(0, 14))) % 16;
                    press = (16'h0001 << a) | (16'h0001 << b);
                end
                for (int k = 0; k < FRAME; k++) begin
                    key_ready = (int'($urandom_range(0, 99)) < ready_pct);
                    pop_m = (q_m.size() > 0) && key_ready;
                    @(posedge clk_div);
                    #1;
                    cyc++;
                    push_m = 1'b0;
                    if (cyc % FRAME == 0) begin
                        res = frame_result(press);
                        if (res == last_res) run++;
                        else begin run = 1; last_res = res; end
                        if (held < 0 && res >= 0 && run == DEB) begin
                            push_m = 1'b1; held = res;
                        end else if (held >= 0 && res == -1 && run == DEB) begin
                            held = -1;
                        end
                    end
                    if (push_m && !(q_m.size() < DEPTH || pop_m)) begin
                        ovf_m  = 1'b1;
                        push_m = 1'b0;
                    end
                    if (pop_m) void'(q_m.pop_front());
                    if (push_m) q_m.push_back(res);
                    check("rnd_keyRow", keyRow, 4'hF ^ (4'h1 << ((cyc % FRAME) / SETTLE)));
                    check("rnd_valid", key_valid, (q_m.size() > 0) ? 1 : 0);
                    check("rnd_value", key_value, (q_m.size() > 0) ? q_m[0] : 0);
                    check("rnd_ovf", overflow, int'(ovf_m));
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
